// File: rtl/johnson_decoder.sv
// Receive-side Johnson code checker: validates each sampled word, decodes it to a
// position index, tracks step continuity with a lock FSM and counts errors.
module johnson_decoder #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    localparam int IW      = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    input  logic             err_clr,
    output logic             dout_valid,
    output logic [IW-1:0]    index,
    output logic             code_err,
    output logic             seq_err,
    output logic             locked,
    output logic [7:0]       err_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IW-1:0]   prev_q, prev_d;
    logic [IW-1:0]   index_q, index_d;
    logic            dv_q, dv_d;
    logic            ce_q, ce_d;
    logic            se_q, se_d;
    logic            locked_q;
    logic [7:0]      err_q, err_d;

    logic            dec_legal;
    logic [IW-1:0]   dec_idx;
    logic [IW-1:0]   next_idx;
    logic            step_adv;
    logic            step_stall;

    // Compare the input against every legal code word; at most one can match.
    always_comb begin
        dec_legal = 1'b0;
        dec_idx   = '0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            logic [WIDTH-1:0] pat;
            pat = '0;
            for (int j = 0; j < WIDTH; j++) begin
                if (k <= WIDTH) pat[j] = (j >= WIDTH - k);
                else            pat[j] = (j < 2 * WIDTH - k);
            end
            if (din == pat) begin
                dec_legal = 1'b1;
                dec_idx   = IW'(k);
            end
        end
    end

    assign next_idx   = (prev_q == IW'(2 * WIDTH - 1)) ? '0 : prev_q + 1'b1;
    assign step_adv   = (dec_idx == next_idx);
    assign step_stall = (dec_idx == prev_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        index_d = index_q;
        dv_d    = 1'b0;
        ce_d    = 1'b0;
        se_d    = 1'b0;
        err_d   = err_q;

        if (din_valid) begin
            if (!dec_legal) begin
                ce_d    = 1'b1;
                state_d = SEARCH;
                cnt_d   = '0;
            end else begin
                dv_d    = 1'b1;
                index_d = dec_idx;
                prev_d  = dec_idx;
                case (state_q)
                    SEARCH: begin
                        state_d = ACQUIRE;
                        cnt_d   = '0;
                    end
                    ACQUIRE: begin
                        if (step_adv) begin
                            cnt_d = cnt_q + 4'd1;
                            if (cnt_q + 4'd1 == 4'(LOCK_CNT)) state_d = LOCKED;
                        end else if (!step_stall) begin
                            se_d  = 1'b1;
                            cnt_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (!step_adv && !step_stall) begin
                            se_d    = 1'b1;
                            state_d = ACQUIRE;
                            cnt_d   = '0;
                        end
                    end
                    default: begin
                        state_d = SEARCH;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        // A clear wins over a same-cycle error; the pulses themselves are unaffected.
        if (err_clr)                          err_d = '0;
        else if ((ce_d || se_d) && err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= SEARCH;
            cnt_q    <= '0;
            prev_q   <= '0;
            index_q  <= '0;
            dv_q     <= 1'b0;
            ce_q     <= 1'b0;
            se_q     <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            index_q  <= index_d;
            dv_q     <= dv_d;
            ce_q     <= ce_d;
            se_q     <= se_d;
            locked_q <= (state_d == LOCKED);
            err_q    <= err_d;
        end
    end

    assign dout_valid = dv_q;
    assign index      = index_q;
    assign code_err   = ce_q;
    assign seq_err    = se_q;
    assign locked     = locked_q;
    assign err_count  = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder: table of samples with hand-computed outputs,
// plus sequences for saturation, clear precedence and asynchronous reset.
module tb_johnson_decoder;

    localparam int WIDTH = 4;
    localparam int IW    = 3;

    logic             clk;
    logic             reset;
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             err_clr;
    logic             dout_valid;
    logic [IW-1:0]    index;
    logic             code_err;
    logic             seq_err;
    logic             locked;
    logic [7:0]       err_count;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          valid;
        logic [3:0]    din;
        logic          clr;
        logic          e_dv;
        logic [2:0]    e_idx;
        logic          e_ce;
        logic          e_se;
        logic          e_lk;
        logic [7:0]    e_err;
        logic [1:0]    e_st;
    } vec_t;

    vec_t vecs[$];

    johnson_decoder #(.WIDTH(WIDTH), .LOCK_CNT(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (din_valid),
        .din        (din),
        .err_clr    (err_clr),
        .dout_valid (dout_valid),
        .index      (index),
        .code_err   (code_err),
        .seq_err    (seq_err),
        .locked     (locked),
        .err_count  (err_count),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [3:0] d, input logic c, input logic dv,
                       input logic [2:0] idx, input logic ce, input logic se, input logic lk,
                       input logic [7:0] err, input logic [1:0] st);
        vec_t r;
        r.valid = v; r.din = d; r.clr = c; r.e_dv = dv; r.e_idx = idx;
        r.e_ce = ce; r.e_se = se; r.e_lk = lk; r.e_err = err; r.e_st = st;
        vecs.push_back(r);
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic c);
        @(negedge clk);
        din_valid = v;
        din       = d;
        err_clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int row, input logic dv, input logic [2:0] idx, input logic ce,
                             input logic se, input logic lk, input logic [7:0] err, input logic [1:0] st);
        chk("dout_valid", row, 32'(dout_valid), 32'(dv));
        chk("index",      row, 32'(index),      32'(idx));
        chk("code_err",   row, 32'(code_err),   32'(ce));
        chk("seq_err",    row, 32'(seq_err),    32'(se));
        chk("locked",     row, 32'(locked),     32'(lk));
        chk("err_count",  row, 32'(err_count),  32'(err));
        chk("state",      row, 32'(dbg_state),  32'(st));
    endtask

    initial begin
        logic [3:0] illegal [8];
        illegal = '{4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1011, 4'b1101};

        reset     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        err_clr   = 1'b0;

        // Free-running sequence: locks on the 4th sample (3 good advances).
        add(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 4'b1000, 0, 1, 1, 0, 0, 0, 0, 1);
        add(1, 4'b1100, 0, 1, 2, 0, 0, 0, 0, 1);
        add(1, 4'b1110, 0, 1, 3, 0, 0, 1, 0, 2);
        add(1, 4'b1111, 0, 1, 4, 0, 0, 1, 0, 2);
        add(1, 4'b0111, 0, 1, 5, 0, 0, 1, 0, 2);
        add(1, 4'b0011, 0, 1, 6, 0, 0, 1, 0, 2);
        add(1, 4'b0001, 0, 1, 7, 0, 0, 1, 0, 2);
        add(1, 4'b0000, 0, 1, 0, 0, 0, 1, 0, 2);
        add(1, 4'b1000, 0, 1, 1, 0, 0, 1, 0, 2);
        add(1, 4'b1100, 0, 1, 2, 0, 0, 1, 0, 2);
        add(1, 4'b1110, 0, 1, 3, 0, 0, 1, 0, 2);
        // Jump 3 -> 6 while locked, then relock.
        add(1, 4'b0011, 0, 1, 6, 0, 1, 0, 1, 1);
        add(1, 4'b0001, 0, 1, 7, 0, 0, 0, 1, 1);
        add(1, 4'b0000, 0, 1, 0, 0, 0, 0, 1, 1);
        add(1, 4'b1000, 0, 1, 1, 0, 0, 1, 1, 2);
        // Illegal word while locked, then stalls in ACQUIRE must not count.
        add(1, 4'b1010, 0, 0, 1, 1, 0, 0, 2, 0);
        add(1, 4'b1100, 0, 1, 2, 0, 0, 0, 2, 1);
        add(1, 4'b1100, 0, 1, 2, 0, 0, 0, 2, 1);
        add(1, 4'b1100, 0, 1, 2, 0, 0, 0, 2, 1);
        add(1, 4'b1110, 0, 1, 3, 0, 0, 0, 2, 1);
        add(1, 4'b1111, 0, 1, 4, 0, 0, 0, 2, 1);
        add(1, 4'b1111, 0, 1, 4, 0, 0, 0, 2, 1);
        add(1, 4'b0111, 0, 1, 5, 0, 0, 1, 2, 2);
        // Locked stalls at index 2.
        add(1, 4'b0011, 0, 1, 6, 0, 0, 1, 2, 2);
        add(1, 4'b0001, 0, 1, 7, 0, 0, 1, 2, 2);
        add(1, 4'b0000, 0, 1, 0, 0, 0, 1, 2, 2);
        add(1, 4'b1000, 0, 1, 1, 0, 0, 1, 2, 2);
        for (int i = 0; i < 5; i++) add(1, 4'b1100, 0, 1, 2, 0, 0, 1, 2, 2);
        // Idle with garbage on din, then clears (one alongside a seq error).
        add(0, 4'b1010, 0, 0, 2, 0, 0, 1, 2, 2);
        add(1, 4'b1110, 1, 1, 3, 0, 0, 1, 0, 2);
        add(1, 4'b0000, 1, 1, 0, 0, 1, 0, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        check_all(-1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int r = 0; r < vecs.size(); r++) begin
            drive(vecs[r].valid, vecs[r].din, vecs[r].clr);
            check_all(r, vecs[r].e_dv, vecs[r].e_idx, vecs[r].e_ce, vecs[r].e_se,
                      vecs[r].e_lk, vecs[r].e_err, vecs[r].e_st);
        end

        // Saturation: 300 illegal words from a cleared count.
        for (int i = 0; i < 300; i++) drive(1, illegal[i % 8], 0);
        check_all(100, 0, 0, 1, 0, 0, 8'd255, 0);
        drive(1, 4'b0110, 1);
        check_all(101, 0, 0, 1, 0, 0, 8'd0, 0);
        drive(1, 4'b1011, 0);
        check_all(102, 0, 0, 1, 0, 0, 8'd1, 0);

        // Relock, then asynchronous reset between edges.
        drive(1, 4'b0000, 0);
        check_all(103, 1, 0, 0, 0, 0, 8'd1, 1);
        drive(1, 4'b1000, 0);
        drive(1, 4'b1100, 0);
        drive(1, 4'b1110, 0);
        check_all(104, 1, 3, 0, 0, 1, 8'd1, 2);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all(105, 0, 0, 0, 0, 0, 8'd0, 0);
        @(negedge clk);
        din_valid = 1'b1;
        din       = 4'b1110;
        err_clr   = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        check_all(106, 1, 3, 0, 0, 0, 8'd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
Name: johnson_decoder

Overview:
- Receive-side checker/decoder for the Johnson-coded count word driven by our Johnson counters.
- Samples the WIDTH-bit code, validates it, and converts it to a binary position index (0..2*WIDTH-1).
- Tracks step-by-step sequence continuity with a lock FSM and keeps a saturating error count.
- Sits on the consumer side of any counter bus, e.g. phase/sequence monitors.

Parameters:
- WIDTH, 4, Johnson code width; the sequence has 2*WIDTH states.
- LOCK_CNT, 3, number of consecutive good steps in ACQUIRE required to enter LOCKED (1..15).
- IW, $clog2(2*WIDTH), index width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (reset==0 resets the block).
- din_valid  input  1  din is sampled on a clk edge when high.
- din  input  WIDTH  Johnson code word.
- err_clr  input  1  synchronous clear of err_count.
- dout_valid  output  1  registered; high one cycle after an accepted legal sample.
- index  output  IW  decoded position; holds its value when dout_valid is low.
- code_err  output  1  one-cycle pulse: accepted sample was an illegal pattern.
- seq_err  output  1  one-cycle pulse: legal sample is not the same as, or the successor of, the previous index.
- locked  output  1  high while the FSM is in LOCKED.
- err_count  output  8  saturating count of code_err and seq_err events.

Behaviour:
- Reset values: all outputs 0; FSM = SEARCH; prev_idx = 0; good-step count = 0.
- Sequence order matches the counter: MSB is loaded with ~LSB and the word shifts right. For WIDTH=4: 0000 -> 1000 -> 1100 -> 1110 -> 1111 -> 0111 -> 0011 -> 0001 -> 0000.
- Decode:
  - MSB=1 with k contiguous ones from the MSB and zeros below: index = k.
  - 0000: index = 0.
  - MSB=0, nonzero, with k contiguous ones from the LSB and zeros above: index = 2*WIDTH-k.
  - Any other pattern is illegal.
- Latency: every output reflects the sample taken at edge N on edge N+1. With no accepted sample, dout_valid, code_err and seq_err are 0 and the other outputs hold.
- Illegal sample, any state:
  - code_err=1, dout_valid=0, index holds.
  - FSM -> SEARCH, good-step count = 0.
- Legal sample: dout_valid=1, index = decoded value.
- Step check (ACQUIRE and LOCKED only):
  - Good step: new == prev_idx (stall) or new == (prev_idx+1) mod 2*WIDTH. Wrap from 2*WIDTH-1 to 0 is a good step.
  - Anything else: seq_err=1.
  - prev_idx <= new on every legal sample.
- FSM:
  - SEARCH: legal sample -> ACQUIRE, count=0; no seq check.
  - ACQUIRE:
    - Good advance (+1): count++; when count reaches LOCK_CNT -> LOCKED.
    - Stall: count unchanged.
    - seq_err: count=0, stay in ACQUIRE.
  - LOCKED:
    - Good step: stay.
    - seq_err: -> ACQUIRE, count=0.
  - locked = (state==LOCKED), registered with the other outputs.
- err_count: +1 per code_err or seq_err pulse event, saturates at 255.
- err_clr precedence: err_clr in the same cycle as an error sets err_count to 0; the event is not counted, but the pulses still fire.
- Reset mid-operation: asynchronous return to the reset values regardless of din_valid.
- Release from reset is synchronous to clk; the first sample is accepted on the first edge with reset==1.

Test Plan:
- Reset released, free-running sequence from 0000 for 12 samples -> index 0,1,2,...,7,0,1,2,3; locked goes high on the output cycle of the 4th sample (3 good steps); no errors; err_count=0.
- When locked, inject 1010 -> code_err pulse, dout_valid=0, locked=0, err_count=1; then 1100 -> index=2, FSM in ACQUIRE.
- When locked at index 3 (1110), inject 0011 (index 6) -> seq_err pulse, locked=0, index=6, err_count+1; then 0001, 0000, 1000 -> relocked.
- Stall: repeat 1100 five times while locked -> index=2 each cycle, no seq_err, locked stays 1; in ACQUIRE, stalls do not advance the lock count.
- Force 300 illegal samples -> err_count saturates at 255; err_clr asserted with an illegal sample -> err_count=0, code_err still pulses.
- Assert reset low mid-stream while locked -> all outputs 0 immediately (before the next edge); after release, the first legal sample gives FSM=ACQUIRE and no seq_err.
